// File: rtl/midi_pkg.sv
// Constants and the rx state encoding shared by the MIDI receiver and the message FSM.
package midi_pkg;

  localparam int         MIDI_BAUD = 31250;
  localparam logic [7:0] RT_MIN    = 8'hF8;
  localparam logic [2:0] NOTE_OFF  = 3'd0;
  localparam logic [2:0] NOTE_ON   = 3'd1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // System Real-Time messages are single bytes 0xF8..0xFF.
  function automatic logic is_realtime(input logic [7:0] b);
    return b >= RT_MIN;
  endfunction

endpackage

// File: rtl/midi_uart_rx_if.sv
// Byte stream from the MIDI UART receiver to its consumer (the message FSM).
interface midi_uart_rx_if;
  logic       new_byte_valid;
  logic [7:0] new_byte_value;
  logic       framing_error;

  modport master (output new_byte_valid, output new_byte_value, output framing_error);
  modport slave  (input  new_byte_valid, input  new_byte_value, input  framing_error);
endinterface

// File: rtl/midi_sync_2ff.sv
// Two-flop synchronizer for an asynchronous input; resets to 1 (idle line level).
module midi_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_reg;
  logic q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b1;
      q_reg    <= 1'b1;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;
endmodule

// File: rtl/midi_uart_rx.sv
// MIDI IN deframer: 8N1 LSB-first, mid-bit sampling, optional System Real-Time drop.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLK_FREQ      = 12000000,
  parameter int BAUD          = MIDI_BAUD,
  parameter int DROP_REALTIME = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rx,
  midi_uart_rx_if.master bus
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic             DROP_RT   = (DROP_REALTIME != 0);

  logic rx_s;

  rx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg,   cnt_next;
  logic [2:0]       idx_reg,   idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             valid_reg, valid_next;
  logic [7:0]       value_reg, value_next;
  logic             ferr_reg,  ferr_next;

  midi_sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      valid_reg <= 1'b0;
      value_reg <= 8'h00;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      valid_reg <= valid_next;
      value_reg <= value_next;
      ferr_reg  <= ferr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    valid_next = 1'b0;
    value_next = value_reg;
    ferr_next  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        // A start bit that is high again at mid-bit was only a glitch.
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next            = '0;
          shift_next[idx_reg] = rx_s;
          if (idx_reg == 3'd7) state_next = STOP;
          else                 idx_next   = idx_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            state_next = IDLE;
            if (!(DROP_RT && is_realtime(shift_reg))) begin
              valid_next = 1'b1;
              value_next = shift_reg;
            end
          end else begin
            ferr_next  = 1'b1;
            state_next = BREAK;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      BREAK: begin
        // Hold off until the line is released so a break cannot start frames.
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.new_byte_valid = valid_reg;
  assign bus.new_byte_value = value_reg;
  assign bus.framing_error  = ferr_reg;
endmodule

// File: tb/tb_midi_uart_rx.sv
// Directed and randomized frames on one rx line into two receivers (real-time drop on / off).
module tb_midi_uart_rx;
  import midi_pkg::*;

  localparam int CLK_HZ = 12000000;
  localparam int CPB    = CLK_HZ / 31250;
  localparam int HALF   = CPB / 2;
  localparam int LAT    = 2 + (HALF - 1) + 9 * CPB + 1;
  localparam int FAST   = 376;
  localparam int SLOW   = 392;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  int unsigned cyc = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  midi_uart_rx_if bus1 ();
  midi_uart_rx_if bus0 ();

  midi_uart_rx #(.CLK_FREQ(CLK_HZ), .BAUD(31250), .DROP_REALTIME(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx), .bus(bus1)
  );
  midi_uart_rx #(.CLK_FREQ(CLK_HZ), .BAUD(31250), .DROP_REALTIME(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx), .bus(bus0)
  );

  typedef struct {
    logic [7:0]  v;
    int unsigned c;
  } ev_t;

  ev_t        obs1[$], obs0[$];
  logic [7:0] exp1[$], exp0[$];
  int         ferr1 = 0, ferr0 = 0;
  logic       pv1 = 1'b0, pf1 = 1'b0, pv0 = 1'b0, pf0 = 1'b0;
  int unsigned t_fall = 0;

  // Pulse capture plus the one-cycle / mutually-exclusive pulse rules.
  always @(negedge clk) begin
    if (bus1.new_byte_valid) obs1.push_back('{bus1.new_byte_value, cyc});
    if (bus0.new_byte_valid) obs0.push_back('{bus0.new_byte_value, cyc});
    if (bus1.framing_error) ferr1++;
    if (bus0.framing_error) ferr0++;
    if (bus1.new_byte_valid || bus1.framing_error) begin
      checks++;
      assert (!(bus1.new_byte_valid && bus1.framing_error) && !pv1 && !pf1)
      else begin
        errors++;
        $error("FAIL pulse1: observed v=%0b f=%0b prev_v=%0b prev_f=%0b expected single exclusive pulse",
               bus1.new_byte_valid, bus1.framing_error, pv1, pf1);
      end
    end
    if (bus0.new_byte_valid || bus0.framing_error) begin
      checks++;
      assert (!(bus0.new_byte_valid && bus0.framing_error) && !pv0 && !pf0)
      else begin
        errors++;
        $error("FAIL pulse0: observed v=%0b f=%0b prev_v=%0b prev_f=%0b expected single exclusive pulse",
               bus0.new_byte_valid, bus0.framing_error, pv0, pf0);
      end
    end
    pv1 = bus1.new_byte_valid;
    pf1 = bus1.framing_error;
    pv0 = bus0.new_byte_valid;
    pf0 = bus0.framing_error;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    rx = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low, input int bl);
    t_fall = cyc;
    drive(1'b0, bl);
    for (int i = 0; i < 8; i++) drive(b[i], bl);
    if (stop_low > 0) drive(1'b0, stop_low * bl);
    drive(1'b1, bl);
    $display("frame %02h bit_len %0d stop_low_bits %0d", b, bl, stop_low);
  endtask

  // Reference: a good frame delivers its byte unless the receiver drops real-time bytes.
  function automatic bit delivered(input logic [7:0] b, input bit drop_rt);
    return !(drop_rt && b >= 8'hF8);
  endfunction

  task automatic expect_byte(input logic [7:0] b);
    if (delivered(b, 1'b1)) exp1.push_back(b);
    if (delivered(b, 1'b0)) exp0.push_back(b);
  endtask

  task automatic drain(input string tag);
    ev_t e;
    check({tag, "_count1"}, obs1.size(), exp1.size());
    check({tag, "_count0"}, obs0.size(), exp0.size());
    while (obs1.size() > 0 && exp1.size() > 0) begin
      e = obs1.pop_front();
      check({tag, "_byte1"}, e.v, exp1.pop_front());
    end
    while (obs0.size() > 0 && exp0.size() > 0) begin
      e = obs0.pop_front();
      check({tag, "_byte0"}, e.v, exp0.pop_front());
    end
    obs1.delete(); obs0.delete(); exp1.delete(); exp0.delete();
  endtask

  initial begin
    int          f1, f0, d, bl;
    logic [7:0]  b;
    logic [7:0]  pat;

    @(negedge clk);
    repeat (4) @(negedge clk);
    check("rst_valid", bus1.new_byte_valid, 1'b0);
    check("rst_value", bus1.new_byte_value, 8'h00);
    check("rst_ferr",  bus1.framing_error, 1'b0);
    check("rst_state", 32'(dut1.state_reg), 32'(IDLE));
    rst_n = 1'b1;
    drive(1'b1, 20);

    // Single byte and its latency from the falling start edge
    expect_byte(8'h90);
    send_frame(8'h90, 0, CPB);
    drive(1'b1, 20);
    d = (obs1.size() > 0) ? int'(obs1[0].c - t_fall) : 0;
    check_range("latency", d, LAT - 1, LAT + 1);
    drain("single");

    // Back-to-back frames with no idle gap
    f1 = ferr1;
    expect_byte(8'h90); expect_byte(8'h3C); expect_byte(8'h64);
    send_frame(8'h90, 0, CPB);
    send_frame(8'h3C, 0, CPB);
    send_frame(8'h64, 0, CPB);
    drive(1'b1, 20);
    d = (obs1.size() >= 3) ? int'(obs1[1].c - obs1[0].c) : 0;
    check("b2b_gap01", d, 10 * CPB);
    d = (obs1.size() >= 3) ? int'(obs1[2].c - obs1[1].c) : 0;
    check("b2b_gap12", d, 10 * CPB);
    check("b2b_ferr", ferr1 - f1, 0);
    drain("b2b");

    // Short low glitch on an idle line
    f1 = ferr1; f0 = ferr0;
    drive(1'b0, 100);
    drive(1'b1, 2 * CPB);
    check("glitch_ferr1", ferr1 - f1, 0);
    check("glitch_ferr0", ferr0 - f0, 0);
    check("glitch_state", 32'(dut1.state_reg), 32'(IDLE));
    drain("glitch");

    // Stop bit held low, then a clean frame once the line is released
    f1 = ferr1; f0 = ferr0;
    send_frame(8'h55, 2, CPB);
    drive(1'b1, CPB);
    check("break_ferr1", ferr1 - f1, 1);
    check("break_ferr0", ferr0 - f0, 1);
    drain("break");
    expect_byte(8'hA5);
    send_frame(8'hA5, 0, CPB);
    drive(1'b1, 20);
    drain("after_break");

    // Real-time byte: dropped by one receiver, passed by the other
    expect_byte(8'hF8);
    send_frame(8'hF8, 0, CPB);
    drive(1'b1, 20);
    drain("realtime");
    check("rt_hold1", bus1.new_byte_value, 8'hA5);
    check("rt_pass0", bus0.new_byte_value, 8'hF8);

    // Reset during bit 4 of 0x90
    pat = 8'h90;
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(pat[i], CPB);
    drive(pat[4], HALF);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_value1", bus1.new_byte_value, 8'h00);
    check("mid_rst_value0", bus0.new_byte_value, 8'h00);
    rst_n = 1'b1;
    drive(1'b1, 2 * CPB);
    drain("aborted");
    check("post_rst_value", bus0.new_byte_value, 8'h00);
    expect_byte(8'h80);
    send_frame(8'h80, 0, CPB);
    drive(1'b1, 20);
    drain("post_rst");

    // Baud mismatch of about +/-2%
    expect_byte(8'h80);
    send_frame(8'h80, 0, SLOW);
    drive(1'b1, 20);
    drain("slow");
    expect_byte(8'h80);
    send_frame(8'h80, 0, FAST);
    drive(1'b1, 20);
    drain("fast");

    // Random bytes, bit lengths and gaps
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom_range(0, 255));
      if (n % 4 == 3) b = 8'($urandom_range(248, 255));
      case ($urandom_range(0, 2))
        0:       bl = FAST;
        1:       bl = SLOW;
        default: bl = CPB;
      endcase
      expect_byte(b);
      send_frame(b, 0, bl);
      drive(1'b1, $urandom_range(0, 40));
    end
    drive(1'b1, 20);
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
